// File: rtl/ram_dp_writer_if.sv
// ----------------------------------------------------------------------------
// ram_dp_writer_if
//   Bundles the download byte stream (loader -> writer) and the RAM write port
//   (writer -> RAM) of ram_dp_writer.
//
//   Handshake: a download byte moves on a rising clock edge where both
//   dl_valid and dl_ready are high. dl_data and dl_last are only meaningful
//   while dl_valid is high. The loader may not make dl_valid depend on
//   dl_ready. dl_ready may drop at any time, and a byte offered while
//   dl_ready is low is simply not taken.
//
//   Signals:
//     dl_valid  loader has a byte on dl_data
//     dl_ready  writer can take a byte this cycle (combinational)
//     dl_data   download byte
//     dl_last   final byte of the current download
//     wa        RAM write address
//     wd        RAM write data
//     we        RAM write enable
//
//   Modports:
//     master  the loader/RAM side (drives dl_*, observes the write port)
//     slave   the writer itself
// ----------------------------------------------------------------------------
interface ram_dp_writer_if #(
  parameter int AW = 17,
  parameter int DW = 8
);
  logic          dl_valid;
  logic          dl_ready;
  logic [DW-1:0] dl_data;
  logic          dl_last;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          we;

  modport master (
    output dl_valid,
    input  dl_ready,
    output dl_data,
    output dl_last,
    input  wa,
    input  wd,
    input  we
  );

  modport slave (
    input  dl_valid,
    output dl_ready,
    input  dl_data,
    input  dl_last,
    output wa,
    output wd,
    output we
  );
endinterface

// File: rtl/ram_dp_writer.sv
// ----------------------------------------------------------------------------
// ram_dp_writer
//   Write-side controller for the dual-port video/program RAM. Turns a
//   download byte stream into RAM write cycles and provides a clear engine
//   that fills the whole address space with CLEAR_VAL.
//
//   Optional feature (macro RAM_WRITER_CSUM_EN): a 16-bit running sum of the
//   accepted download bytes, reported with the download done pulse.
//
//   Parameters:
//     AW         RAM address width (2^AW bytes)
//     DW         data width (the checksum assumes DW <= 16)
//     CLEAR_VAL  fill value written by the clear engine
//
//   Ports:
//     clk          RAM write clock, everything on its rising edge
//     reset_n      asynchronous active-low reset
//     start_clear  one-cycle request for a full-RAM clear
//     bus          download stream + RAM write port (ram_dp_writer_if.slave)
//     busy         high while the clear engine runs
//     done         one-cycle pulse at the end of a clear or a download
//     overflow     sticky: a download ran past the top address and wrapped
//     state_dbg    current FSM state (IDLE/CLEAR/FINISH encoding below)
//     csum         (RAM_WRITER_CSUM_EN) running sum of download bytes
//     csum_valid   (RAM_WRITER_CSUM_EN) pulse with the final sum, with done
//
//   Write latency is one cycle: a byte accepted on edge N appears on
//   wa/wd/we after edge N. wa/wd hold their last values while we is low.
// ----------------------------------------------------------------------------
module ram_dp_writer #(
  parameter int            AW        = 17,
  parameter int            DW        = 8,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_clear,
  ram_dp_writer_if.slave      bus,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [1:0]          state_dbg
`ifdef RAM_WRITER_CSUM_EN
  ,
  output logic [15:0]         csum,
  output logic                csum_valid
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [AW-1:0] PTR_TOP = '1;

  logic [1:0]    state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] wa_q;
  logic [DW-1:0] wd_q;
  logic          we_q;
  logic          busy_q;
  logic          done_q;
  logic          ovf_q;

  logic          dl_ready_c;
  logic          accept;

  // A clear request in the same cycle as a download byte wins: ready is
  // dropped so the byte stays with the loader.
  assign dl_ready_c = (state == ST_IDLE) && !start_clear;
  assign accept     = bus.dl_valid && dl_ready_c;

  assign bus.dl_ready = dl_ready_c;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign bus.we       = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign state_dbg    = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      wa_q   <= '0;
      wd_q   <= '0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      // Single-cycle strobes; re-asserted below only when a cycle needs them.
      we_q   <= 1'b0;
      done_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_clear) begin
            state  <= ST_CLEAR;
            ptr    <= '0;
            busy_q <= 1'b1;
            ovf_q  <= 1'b0;
          end else if (accept) begin
            we_q <= 1'b1;
            wa_q <= ptr;
            wd_q <= bus.dl_data;
            if (bus.dl_last) begin
              // Next download starts again at address 0.
              ptr    <= '0;
              done_q <= 1'b1;
            end else begin
              // Wrapping only counts as overflow when more data follows.
              if (ptr == PTR_TOP) begin
                ovf_q <= 1'b1;
              end
              ptr <= ptr + 1'b1;
            end
          end
        end

        ST_CLEAR: begin
          we_q <= 1'b1;
          wa_q <= ptr;
          wd_q <= CLEAR_VAL;
          ptr  <= ptr + 1'b1;
          if (ptr == PTR_TOP) begin
            state <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          ptr    <= '0;
          state  <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          ptr    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_WRITER_CSUM_EN
  logic [15:0] csum_q;
  logic        csum_valid_q;
  logic [15:0] csum_base;

  // The sum is held for the done cycle and restarts from zero afterwards;
  // a byte accepted in that same cycle becomes the first term of the next sum.
  assign csum_base = csum_valid_q ? 16'h0000 : csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      csum_valid_q <= 1'b0;
      if (state == ST_IDLE && start_clear) begin
        csum_q <= '0;
      end else if (accept) begin
        csum_q <= csum_base + 16'(bus.dl_data);
        if (bus.dl_last) begin
          csum_valid_q <= 1'b1;
        end
      end else begin
        csum_q <= csum_base;
      end
    end
  end

  assign csum       = csum_q;
  assign csum_valid = csum_valid_q;
`endif

endmodule

// File: tb/tb_ram_dp_writer.sv
// ----------------------------------------------------------------------------
// tb_ram_dp_writer
//   Bench for ram_dp_writer built with AW=4, CLEAR_VAL=8'hA5 so the full
//   address space (16 bytes) is cheap to clear and easy to wrap.
//   Inputs are driven on the falling edge; outputs are sampled on the
//   falling edge that follows the rising edge that produced them.
// ----------------------------------------------------------------------------
module tb_ram_dp_writer;

  localparam int         AW    = 4;
  localparam int         DW    = 8;
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] CV    = 8'hA5;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_clear = 1'b0;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [1:0] state_dbg;
`ifdef RAM_WRITER_CSUM_EN
  logic [15:0] csum;
  logic        csum_valid;
`endif

  ram_dp_writer_if #(.AW(AW), .DW(DW)) bus ();

  ram_dp_writer #(.AW(AW), .DW(DW), .CLEAR_VAL(CV)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_clear (start_clear),
    .bus         (bus.slave),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .state_dbg   (state_dbg)
`ifdef RAM_WRITER_CSUM_EN
    ,
    .csum        (csum),
    .csum_valid  (csum_valid)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  // {done, wa[3:0], wd[7:0]} of each write the model expects next cycle
  logic [12:0] exp_q[$];
  logic [15:0] csum_q[$];

  int          m_ptr;
  bit          m_ovf;
  logic [15:0] m_sum;
  logic [7:0]  m_mem [DEPTH];
  logic [7:0]  shadow [DEPTH];

  // The RAM as the DUT actually writes it.
  always @(negedge clk) begin
    if (bus.we === 1'b1) shadow[bus.wa] <= bus.wd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.dl_valid = 1'b0;
    bus.dl_data  = '0;
    bus.dl_last  = 1'b0;
    start_clear  = 1'b0;
  endtask

  // Starts a clear with a download byte offered at the same time and
  // walks through the whole clear cycle by cycle. Called at a falling edge.
  task automatic clear_and_check();
    start_clear  = 1'b1;
    bus.dl_valid = 1'b1;
    bus.dl_data  = 8'h77;
    bus.dl_last  = 1'b0;
    #1 check("ready_low_on_start_clear", bus.dl_ready, 1'b0);
    @(negedge clk);
    start_clear = 1'b0;
    check("clr_busy_rise", busy, 1'b1);
    check("clr_no_write_first", bus.we, 1'b0);
    check("clr_ovf_cleared", overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("clr_we", bus.we, 1'b1);
      check("clr_wa", bus.wa, i);
      check("clr_wd", bus.wd, CV);
      check("clr_ready_low", bus.dl_ready, 1'b0);
      check("clr_busy", busy, 1'b1);
      check("clr_no_done", done, 1'b0);
    end
    @(negedge clk);
    bus.dl_valid = 1'b0;
    check("clr_finish_we", bus.we, 1'b0);
    check("clr_finish_done", done, 1'b1);
    check("clr_finish_busy", busy, 1'b0);
    #1 check("clr_ready_back", bus.dl_ready, 1'b1);
    @(negedge clk);
    check("clr_done_single", done, 1'b0);
    check("clr_idle_we", bus.we, 1'b0);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = CV;
    m_ptr = 0;
    m_ovf = 1'b0;
    m_sum = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [3:0]  exp_wa;
    logic        exp_done;
    logic        exp_ovf;
    logic [15:0] exp_csum;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    logic [12:0] e;
    bit          v;

    // Two short downloads, then 17 bytes without a last byte.
    vecs[0] = '{8'h11, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{8'h22, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{8'h33, 1'b1, 4'd2, 1'b1, 1'b0, 16'h0066};
    vecs[3] = '{8'hFF, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{8'hFF, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{8'h03, 1'b1, 4'd2, 1'b1, 1'b0, 16'h0201};
    for (int k = 0; k < 17; k++) begin
      vecs[6+k] = '{8'h40 + 8'(k), 1'b0, 4'(k % 16), 1'b0, (k >= 15), 16'h0000};
    end

    idle_inputs();

    // ---- reset state ----
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", bus.we, 1'b0);
    check("rst_wa", bus.wa, 0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_wd", bus.wd, 0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    check("rst_ready", bus.dl_ready, 1'b1);

    // ---- clear with a competing download byte ----
    clear_and_check();

    // ---- table-driven streaming, dl_valid held ----
    bus.dl_valid = 1'b1;
    bus.dl_data  = vecs[0].data;
    bus.dl_last  = vecs[0].last;
    #1 check("tbl_ready", bus.dl_ready, 1'b1);
    for (int i = 1; i <= NV; i++) begin
      @(negedge clk);
      check("tbl_we", bus.we, 1'b1);
      check("tbl_wa", bus.wa, vecs[i-1].exp_wa);
      check("tbl_wd", bus.wd, vecs[i-1].data);
      check("tbl_done", done, vecs[i-1].exp_done);
      check("tbl_ovf", overflow, vecs[i-1].exp_ovf);
`ifdef RAM_WRITER_CSUM_EN
      check("tbl_csum_valid", csum_valid, vecs[i-1].last);
      if (vecs[i-1].last) check("tbl_csum", csum, vecs[i-1].exp_csum);
`endif
      if (i < NV) begin
        bus.dl_data = vecs[i].data;
        bus.dl_last = vecs[i].last;
      end else begin
        bus.dl_valid = 1'b0;
        bus.dl_last  = 1'b0;
      end
    end
    @(negedge clk);
    check("tbl_stop_we", bus.we, 1'b0);
    check("tbl_ovf_sticky", overflow, 1'b1);

    // ---- clear drops the sticky overflow ----
    clear_and_check();

    // ---- reset in the middle of a clear ----
    start_clear = 1'b1;
    @(negedge clk);
    start_clear = 1'b0;
    for (int n = 0; n < 40 && !(bus.we === 1'b1 && bus.wa == 4'd7); n++) @(negedge clk);
    check("mid_rst_reach_wa7", bus.wa, 7);
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", bus.we, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_wa", bus.wa, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_done", done, 1'b0);
      check("post_rst_we", bus.we, 1'b0);
      check("post_rst_state", state_dbg, 2'd0);
      check("post_rst_wa", bus.wa, 0);
    end

    // ---- randomized downloads against the model ----
    clear_and_check();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rnd_we", bus.we, 1'b1);
        check("rnd_wa", bus.wa, e[11:8]);
        check("rnd_wd", bus.wd, e[7:0]);
        check("rnd_done", done, e[12]);
`ifdef RAM_WRITER_CSUM_EN
        check("rnd_csum_valid", csum_valid, e[12]);
        if (e[12]) check("rnd_csum", csum, csum_q.pop_front());
`endif
      end else begin
        check("rnd_idle_we", bus.we, 1'b0);
        check("rnd_idle_done", done, 1'b0);
      end
      check("rnd_ovf", overflow, m_ovf);

      v = ($urandom_range(0, 3) != 0);
      bus.dl_valid = v;
      bus.dl_data  = 8'($urandom_range(0, 255));
      bus.dl_last  = ($urandom_range(0, 11) == 0);
      #1 check("rnd_ready", bus.dl_ready, 1'b1);
      if (v) begin
        exp_q.push_back({bus.dl_last, 4'(m_ptr), bus.dl_data});
        m_mem[m_ptr] = bus.dl_data;
        if (bus.dl_last) begin
          csum_q.push_back(m_sum + 16'(bus.dl_data));
          m_sum = '0;
          m_ptr = 0;
        end else begin
          m_sum = m_sum + 16'(bus.dl_data);
          if (m_ptr == DEPTH - 1) m_ovf = 1'b1;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rnd_tail_we", bus.we, 1'b1);
      check("rnd_tail_wa", bus.wa, e[11:8]);
      check("rnd_tail_wd", bus.wd, e[7:0]);
      check("rnd_tail_done", done, e[12]);
    end
    @(negedge clk);
    check("rnd_end_we", bus.we, 1'b0);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      check("ram_contents", shadow[i], m_mem[i]);
    end

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
